// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write side -- RAM write port, Gray write pointer, synchronized read pointer, level and status flags.
module fifo_wr_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 16,
  parameter int FTHR  = 800
) (
  input  logic             wrclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_din,
  input  logic [ABITS:0]   rd_gray_ptr,
  input  logic             ovf_clr,
  output logic [ABITS:0]   wr_gray_ptr,
  output logic             ram_we,
  output logic [ABITS-1:0] ram_waddr,
  output logic [DBITS-1:0] ram_wdata,
  output logic             wr_full,
  output logic             wr_afull,
  output logic [ABITS:0]   wr_level,
  output logic             wr_ovf
);
  logic [1:0]       rst_sq;
  logic             arst;
  logic [ABITS:0]   wr_bin_q, bin_d, gray_d, level_d, rd_s0_q, rd_s1_q, rd_bin;
  logic             accept, full_d, afull_d, ovf_d;
  // reset asserts immediately, releases two wrclk edges later
  always_ff @(posedge wrclk or posedge rst)
    if (rst) rst_sq <= '1;
    else     rst_sq <= {rst_sq[0], 1'b0};
  assign arst = rst_sq[1];
  for (genvar g = 0; g <= ABITS; g++) begin : g_g2b
    assign rd_bin[g] = ^rd_s1_q[ABITS:g];
  end
  assign accept  = wr_en & ~wr_full;
  assign bin_d   = wr_bin_q + (ABITS+1)'(accept);
  assign gray_d  = bin_d ^ (bin_d >> 1);
  assign level_d = bin_d - rd_bin;
  assign full_d  = gray_d == {~rd_s1_q[ABITS:ABITS-1], rd_s1_q[ABITS-2:0]};
  assign afull_d = level_d >= (ABITS+1)'(FTHR);
  assign ovf_d   = (wr_en & wr_full) | (wr_ovf & ~ovf_clr);
  always_ff @(posedge wrclk or posedge arst)
    if (arst) begin
      wr_bin_q    <= '0;
      rd_s0_q     <= '0;
      rd_s1_q     <= '0;
      wr_gray_ptr <= '0;
      ram_we      <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
      wr_full     <= 1'b0;
      wr_afull    <= 1'b0;
      wr_level    <= '0;
      wr_ovf      <= 1'b0;
    end else begin
      rd_s0_q     <= rd_gray_ptr;
      rd_s1_q     <= rd_s0_q;
      wr_bin_q    <= bin_d;
      wr_gray_ptr <= gray_d;
      ram_we      <= accept;
      if (accept) begin
        ram_waddr <= wr_bin_q[ABITS-1:0];
        ram_wdata <= wr_din;
      end
      wr_full     <= full_d;
      wr_afull    <= afull_d;
      wr_level    <= level_d;
      wr_ovf      <= ovf_d;
    end
endmodule
